uart_recv_b8: RTL and testbench
===============================

Name: uart_recv_b8

Overview:
Receives an 8-byte burst on the UART line and assembles it into one 64-bit word. Byte 0 maps to uart_dout[7:0] and byte 7 to uart_dout[63:56], matching the byte order of the 64-bit transmit path. It sits between the board RX pin and the cipher/temperature datapath, and presents a one-cycle completion pulse with the assembled word.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
UART_BPS, 9600, baud rate; BPS_CNT = CLK_FREQ/UART_BPS clocks per bit (integer division).
TIMEOUT_BYTES, 4, inter-byte idle limit in byte-times (10 bits each); used only with the optional feature.

Ports:
sys_clk  in  1  system clock, all logic on rising edge.
sys_rst  in  1  synchronous, active-high reset.
uart_rxd  in  1  asynchronous serial input, idle high.
uart_dout  out  64  last complete assembled word.
uart_done  out  1  one-cycle pulse when uart_dout is updated.
rx_busy  out  1  high while the bit FSM is not IDLE or rx_cnt != 0.
rx_cnt  out  4  bytes received in the current burst, 0..7.
frame_err  out  1  one-cycle pulse on a bad stop bit.
timeout_err  out  1  one-cycle pulse on inter-byte timeout; constant 0 without the macro.

Behaviour:
- Reset (sys_rst high at a clock edge) clears everything. uart_dout=0, uart_done=0, rx_busy=0, rx_cnt=0, frame_err=0, timeout_err=0. The shadow register, counters and FSM go to IDLE. Reset mid-byte or mid-burst discards all partial data.
- uart_rxd passes through a 2-FF synchronizer. A start is the falling edge of the synchronized signal (prev=1, cur=0).
- Bit FSM states:
  - IDLE -> START on a falling edge.
  - START: at clk_cnt == BPS_CNT/2-1, sample the line. If 1 (glitch), go to IDLE with no error. If 0, clear clk_cnt and go to DATA.
  - DATA: sample at clk_cnt == BPS_CNT-1 (mid-bit), 8 bits, LSB first, then go to STOP.
  - STOP: sample at mid-bit, then go to IDLE immediately, so the next start edge in the second half of the stop bit is accepted.
- Stop sample = 1: byte_valid pulses on the next cycle with the byte.
- Stop sample = 0: frame_err pulses on the next cycle. The byte is discarded, rx_cnt goes to 0 and the shadow register is cleared.
- Assembler, on byte_valid with rx_cnt = n < 7: write shadow[8n+7:8n] and increment rx_cnt.
- Assembler, on byte_valid with rx_cnt = 7: on the same edge, load uart_dout = {byte, shadow[55:0]}, assert uart_done for exactly 1 cycle, and set rx_cnt = 0. Latency is uart_done high 1 cycle after byte_valid, i.e. 2 cycles after the stop-bit sample.
- uart_dout holds its value until the next complete burst. An error never modifies uart_dout.
- frame_err and byte_valid are mutually exclusive per byte. uart_done and frame_err never pulse in the same cycle.

Optional Feature:
UART_RX_TIMEOUT_EN.
- Defined: an idle counter increments while rx_cnt != 0 and the bit FSM is IDLE, and clears on any start edge. At TIMEOUT_BYTES*10*BPS_CNT counts:
  - timeout_err pulses for 1 cycle;
  - rx_cnt goes to 0 and the shadow register is cleared;
  - uart_dout is unchanged.
- Undefined: no idle counter, a partial burst persists indefinitely, and timeout_err is tied to 0.

Decomposition:
- Shared header/package uart_defs holds:
  - the BPS_CNT derivation macro;
  - the bit-FSM state encodings IDLE/START/DATA/STOP (2-bit);
  - BYTES_PER_WORD=8 and the byte counter width (4).
- Sub-module uart_recv (bit level) contains the synchronizer, bit FSM and stop check. It outputs byte_valid, byte_data[7:0], frame_err and busy.
- uart_recv_b8 contains the assembler, shadow register, rx_cnt and the timeout.

Test Plan:
Bench parameters are CLK_FREQ=1_000_000 and UART_BPS=100_000, so BPS_CNT=10.
1. Send bytes 0x01..0x08 with a 1-bit idle between bytes -> uart_dout=64'h0807060504030201. uart_done is a single 1-cycle pulse, 2 cycles after the byte-7 stop sample. rx_cnt ends at 0.
2. Drive a 3-clock low glitch on uart_rxd -> no byte_valid and no frame_err, rx_cnt=0, FSM back in IDLE within 7 cycles.
3. Send 3 good bytes, then a 4th byte with stop bit 0 -> frame_err pulses once, rx_cnt=0, uart_dout unchanged. Then send 8 bytes 0xA0..0xA7 -> uart_dout=64'hA7A6A5A4A3A2A1A0.
4. Send two back-to-back bursts with each start bit beginning right after the stop-bit midpoint: 0x11..0x18 then 0x21..0x28 -> two uart_done pulses with 64'h1817161514131211, then 64'h2827262524232221.
5. Assert sys_rst for 1 cycle after 4 bytes -> all outputs 0 the next cycle. Then send 8 bytes 0xFF -> uart_dout=64'hFFFFFFFFFFFFFFFF.
6. With UART_RX_TIMEOUT_EN, send 3 bytes then idle 400 clocks -> timeout_err pulses, rx_cnt=0. Without the macro, the same stimulus leaves rx_cnt=3 and timeout_err=0.

Source files
------------

// File: rtl/uart_defs_pkg.sv
// Shared definitions for the 8-byte UART receive path: baud divider macro,
// bit-FSM state encoding and word/byte-counter sizing.
`ifndef UART_DEFS_PKG_SV
`define UART_DEFS_PKG_SV

`define UART_BPS_CNT(clk_freq, bps) ((clk_freq) / (bps))

package uart_defs_pkg;

    localparam int BYTES_PER_WORD = 8;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

`endif

// File: rtl/uart_recv.sv
// Bit-level UART receiver: 2-FF synchronizer, start/data/stop FSM and stop check.
// Emits one byte_valid or one frame_err pulse per received frame.
module uart_recv
    import uart_defs_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int UART_BPS = 9600
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       busy
);

    localparam int BPS_CNT = `UART_BPS_CNT(CLK_FREQ, UART_BPS);
    localparam int HALF    = BPS_CNT / 2;
    localparam int CLK_W   = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;

    rx_state_t        state, state_nxt;
    logic [CLK_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic             rxd_meta, rxd_sync, rxd_prev;
    logic             fall;
    logic             clk_clr, sample_bit, stop_sample;

    // Synchronizer flops reset to the idle-high line level so reset never fakes a start.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign fall = rxd_prev & ~rxd_sync;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        clk_clr     = 1'b0;
        sample_bit  = 1'b0;
        stop_sample = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                    clk_clr   = 1'b1;
                end
            end
            START: begin
                if (clk_cnt == CLK_W'(HALF - 1)) begin
                    if (rxd_sync) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        clk_clr   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (clk_cnt == CLK_W'(BPS_CNT - 1)) begin
                    sample_bit = 1'b1;
                    clk_clr    = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave at the stop midpoint so a start edge in its second half is caught.
                if (clk_cnt == CLK_W'(BPS_CNT - 1)) begin
                    stop_sample = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (clk_clr || state == IDLE) clk_cnt <= '0;
            else                          clk_cnt <= clk_cnt + 1'b1;

            if (state == IDLE)   bit_cnt <= '0;
            else if (sample_bit) bit_cnt <= bit_cnt + 1'b1;

            if (sample_bit) byte_data <= {rxd_sync, byte_data[7:1]};

            byte_valid <= stop_sample &  rxd_sync;
            frame_err  <= stop_sample & ~rxd_sync;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/uart_recv_b8.sv
// Assembles eight received UART bytes into one 64-bit word (byte 0 in [7:0]).
// Optional inter-byte timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_recv_b8
    import uart_defs_pkg::*;
#(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int UART_BPS      = 9600,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             uart_rxd,
    output logic [63:0]      uart_dout,
    output logic             uart_done,
    output logic             rx_busy,
    output logic [CNT_W-1:0] rx_cnt,
    output logic             frame_err,
    output logic             timeout_err
);

    localparam int TIMEOUT_LIMIT = TIMEOUT_BYTES * 10 * `UART_BPS_CNT(CLK_FREQ, UART_BPS);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        bit_busy;
    logic        timeout_hit;
    logic [55:0] shadow;

    uart_recv #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_rx (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .uart_rxd   (uart_rxd),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .busy       (bit_busy)
    );

    // NOTE: the shadow register is reset explicitly because a reset must discard partial bursts.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            shadow    <= '0;
            rx_cnt    <= '0;
            uart_dout <= '0;
            uart_done <= 1'b0;
        end else begin
            uart_done <= 1'b0;
            if (frame_err || timeout_hit) begin
                rx_cnt <= '0;
                shadow <= '0;
            end else if (byte_valid) begin
                if (rx_cnt == LAST_BYTE) begin
                    uart_dout <= {byte_data, shadow};
                    uart_done <= 1'b1;
                    rx_cnt    <= '0;
                end else begin
                    shadow[{rx_cnt[2:0], 3'b000} +: 8] <= byte_data;
                    rx_cnt <= rx_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign rx_busy = bit_busy || (rx_cnt != '0);

`ifdef UART_RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_LIMIT + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_run;

    // Any bit-FSM activity (start edge onward) or a fresh byte restarts the idle window.
    assign idle_run    = (rx_cnt != '0) && !bit_busy && !byte_valid;
    assign timeout_hit = idle_run && (idle_cnt == IDLE_W'(TIMEOUT_LIMIT - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if (!idle_run || timeout_hit) idle_cnt <= '0;
            else                          idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_limit;

    assign unused_limit = 32'(TIMEOUT_LIMIT);
    assign timeout_hit  = 1'b0;
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_recv_b8.sv
// Scoreboard bench for uart_recv_b8 at BPS_CNT=10; honours UART_RX_TIMEOUT_EN.
module tb_uart_recv_b8;

    localparam int CLK_FREQ = 1_000_000;
    localparam int UART_BPS = 100_000;
    localparam int BPS      = CLK_FREQ / UART_BPS;
    // Start fall -> 2 sync flops + edge register, half bit, 9 bits to stop sample, +1 assembler.
    localparam int DONE_LAT = 3 + BPS / 2 + 9 * BPS + 1;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        uart_rxd = 1'b1;
    logic [63:0] uart_dout;
    logic        uart_done;
    logic        rx_busy;
    logic [3:0]  rx_cnt;
    logic        frame_err;
    logic        timeout_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          ferr_cnt = 0;
    int          tout_cnt = 0;
    int          last_start_cyc = 0;
    int          last_done_cyc  = 0;
    logic [63:0] exp_q[$];

    uart_recv_b8 #(
        .CLK_FREQ      (CLK_FREQ),
        .UART_BPS      (UART_BPS),
        .TIMEOUT_BYTES (4)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .uart_rxd    (uart_rxd),
        .uart_dout   (uart_dout),
        .uart_done   (uart_done),
        .rx_busy     (rx_busy),
        .rx_cnt      (rx_cnt),
        .frame_err   (frame_err),
        .timeout_err (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every completion pulse.
    always @(negedge sys_clk) begin
        if (frame_err)   ferr_cnt++;
        if (timeout_err) tout_cnt++;
        if (uart_done) begin
            logic [63:0] exp_word;
            done_cnt++;
            last_done_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: got uart_dout=%h, no word expected", uart_dout);
            end else begin
                exp_word = exp_q.pop_front();
                if (uart_dout !== exp_word) begin
                    n_fail++;
                    $display("FAIL sb_word: got %h, expected %h", uart_dout, exp_word);
                end
            end
            n_checks++;
            if (frame_err !== 1'b0) begin
                n_fail++;
                $display("FAIL done_vs_frame_err: frame_err=%b with uart_done, expected 0", frame_err);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                             input int stop_clks, input int gap_clks);
        uart_rxd = 1'b0;
        last_start_cyc = cyc;
        repeat (BPS) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (BPS) @(negedge sys_clk);
        end
        uart_rxd = stop_bit;
        repeat (stop_clks) @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (gap_clks) @(negedge sys_clk);
    endtask

    task automatic send_burst(input logic [63:0] word, input int stop_clks, input int gap_clks);
        exp_q.push_back(word);
        for (int k = 0; k < 8; k++) send_byte(word[8*k +: 8], 1'b1, stop_clks, gap_clks);
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 4 * DONE_LAT) begin
            @(negedge sys_clk);
            n++;
        end
        n_checks++;
        if (done_cnt != target) begin
            n_fail++;
            $display("FAIL %s_done_count: got %0d pulses, expected %0d", name, done_cnt, target);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if (uart_dout !== 64'h0 || uart_done !== 1'b0 || rx_busy !== 1'b0 ||
            rx_cnt !== 4'd0 || frame_err !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got dout=%h done=%b busy=%b cnt=%0d ferr=%b terr=%b, expected all 0",
                     name, uart_dout, uart_done, rx_busy, rx_cnt, frame_err, timeout_err);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        check_all_zero("reset_held");
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        check_all_zero("reset_released");
    endtask

    task automatic test_burst();
        int d0 = done_cnt;
        send_burst(64'h0807060504030201, BPS, BPS);
        wait_done(d0 + 1, "burst");
        n_checks++;
        if (last_done_cyc - last_start_cyc != DONE_LAT) begin
            n_fail++;
            $display("FAIL burst_latency: got %0d cycles, expected %0d",
                     last_done_cyc - last_start_cyc, DONE_LAT);
        end
        n_checks++;
        if (rx_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL burst_rx_cnt: got %0d, expected 0", rx_cnt);
        end
    endtask

    task automatic test_glitch();
        int  f0 = ferr_cnt;
        int  n  = 0;
        bit  saw_busy = 0;
        uart_rxd = 1'b0;
        repeat (3) @(negedge sys_clk);
        uart_rxd = 1'b1;
        while (n < 7) begin
            @(negedge sys_clk);
            n++;
            if (rx_busy) saw_busy = 1;
            else if (saw_busy) break;
        end
        n_checks++;
        if (!saw_busy || rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_fsm: saw_busy=%0d busy_now=%b, expected 1 then 0 within 7 cycles",
                     saw_busy, rx_busy);
        end
        repeat (2 * BPS) @(negedge sys_clk);
        n_checks++;
        if (ferr_cnt != f0 || rx_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL glitch_effects: frame_err pulses=%0d rx_cnt=%0d, expected 0 and 0",
                     ferr_cnt - f0, rx_cnt);
        end
    endtask

    task automatic test_frame_err();
        int f0 = ferr_cnt;
        int d0 = done_cnt;
        send_byte(8'h31, 1'b1, BPS, BPS);
        send_byte(8'h32, 1'b1, BPS, BPS);
        send_byte(8'h33, 1'b1, BPS, BPS);
        n_checks++;
        if (rx_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL ferr_partial_cnt: got %0d, expected 3", rx_cnt);
        end
        send_byte(8'h34, 1'b0, BPS, BPS);
        n_checks++;
        if (ferr_cnt != f0 + 1) begin
            n_fail++;
            $display("FAIL ferr_pulse: got %0d pulses, expected 1", ferr_cnt - f0);
        end
        n_checks++;
        if (rx_cnt !== 4'd0 || uart_dout !== 64'h0807060504030201 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL ferr_state: cnt=%0d dout=%h done=%0d, expected 0 0807060504030201 0",
                     rx_cnt, uart_dout, done_cnt - d0);
        end
        send_burst(64'hA7A6A5A4A3A2A1A0, BPS, BPS);
        wait_done(d0 + 1, "ferr_recover");
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        send_burst(64'h1817161514131211, BPS / 2 + 2, 0);
        send_burst(64'h2827262524232221, BPS / 2 + 2, 0);
        repeat (2 * BPS) @(negedge sys_clk);
        wait_done(d0 + 2, "b2b");
        n_checks++;
        if (ferr_cnt != 1) begin
            n_fail++;
            $display("FAIL b2b_frame_err: got %0d total pulses, expected 1", ferr_cnt);
        end
    endtask

    task automatic test_mid_burst_reset();
        int d0 = done_cnt;
        for (int k = 0; k < 4; k++) send_byte(8'h40 + 8'(k), 1'b1, BPS, BPS);
        n_checks++;
        if (rx_cnt !== 4'd4) begin
            n_fail++;
            $display("FAIL rst_partial_cnt: got %0d, expected 4", rx_cnt);
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check_all_zero("mid_burst_reset");
        send_burst(64'hFFFFFFFFFFFFFFFF, BPS, BPS);
        wait_done(d0 + 1, "after_reset");
    endtask

    task automatic test_timeout();
        int t0 = tout_cnt;
        for (int k = 0; k < 3; k++) send_byte(8'h50 + 8'(k), 1'b1, BPS, BPS);
        repeat (400) @(negedge sys_clk);
`ifdef UART_RX_TIMEOUT_EN
        n_checks++;
        if (tout_cnt != t0 + 1 || rx_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL timeout_on: pulses=%0d rx_cnt=%0d, expected 1 and 0", tout_cnt - t0, rx_cnt);
        end
`else
        n_checks++;
        if (tout_cnt != t0 || rx_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL timeout_off: pulses=%0d rx_cnt=%0d, expected 0 and 3", tout_cnt - t0, rx_cnt);
        end
`endif
        n_checks++;
        if (uart_dout !== 64'hFFFFFFFFFFFFFFFF) begin
            n_fail++;
            $display("FAIL timeout_dout: got %h, expected ffffffffffffffff", uart_dout);
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_mid_burst_reset();
        test_timeout();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d words never completed, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
